// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding and reset vector for the multicycle sequencer
package mc_pkg;
  typedef enum logic [2:0] {
    IF_REQ   = 3'd0,
    IF_WAIT  = 3'd1,
    ID       = 3'd2,
    EXE      = 3'd3,
    MEM_REQ  = 3'd4,
    MEM_WAIT = 3'd5,
    WB       = 3'd6,
    HALT     = 3'd7
  } state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
endpackage

// File: rtl/mc_tmo_cnt.sv
// mc_tmo_cnt: response-timeout counter; expired flags the cycle whose increment reaches the limit
module mc_tmo_cnt #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!resetn || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign expired = en && cnt == LAST;
endmodule

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multicycle fetch/decode/execute/memory/writeback sequencer with SRAM timeouts
module mc_seq_ctrl
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              TMO_W    = 8
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_gnt,
  input  logic            inst_rvalid,
  input  logic [31:0]     inst_rdata,
  output logic            data_req,
  output logic            data_wr,
  output logic [XLEN-1:0] data_addr,
  input  logic            data_gnt,
  input  logic            data_rvalid,
  input  logic [31:0]     data_rdata,
  output logic [31:0]     dec_inst,
  input  logic            dec_is_ld,
  input  logic            dec_is_st,
  input  logic            dec_no_wb,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     load_data,
  output logic            rf_we,
  output logic [2:0]      state,
  output logic            err,
  output logic [XLEN-1:0] debug_wb_pc,
  output logic [3:0]      debug_wb_rf_we
);
  state_t state_q, state_d;
  logic tmo, waiting, retire;
  assign waiting = state_q inside {IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT};
  mc_tmo_cnt #(.TMO_W(TMO_W)) u_tmo (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (state_d != state_q),
    .en      (waiting),
    .expired (tmo)
  );
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IF_REQ;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_REQ:   state_d = inst_gnt ? IF_WAIT : tmo ? HALT : IF_REQ;
      IF_WAIT:  state_d = inst_rvalid ? ID : tmo ? HALT : IF_WAIT;
      ID:       state_d = dec_no_wb ? IF_REQ : EXE;
      EXE:      state_d = (dec_is_ld || dec_is_st) ? MEM_REQ : WB;
      MEM_REQ:  state_d = data_gnt ? MEM_WAIT : tmo ? HALT : MEM_REQ;
      MEM_WAIT: state_d = data_rvalid ? (dec_is_ld ? WB : IF_REQ) : tmo ? HALT : MEM_WAIT;
      WB:       state_d = IF_REQ;
      default:  state_d = HALT;
    endcase
  end
  always_comb begin
    inst_req       = state_q == IF_REQ;
    data_req       = resetn && state_q == MEM_REQ;
    data_wr        = data_req && dec_is_st;
    rf_we          = resetn && state_q == WB;
    debug_wb_rf_we = {4{rf_we}};
  end
  assign retire = (state_q == ID && dec_no_wb) || state_q == WB ||
                  (state_q == MEM_WAIT && data_rvalid && !dec_is_ld);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc        <= RESET_PC;
      dec_inst  <= '0;
      load_data <= '0;
      data_addr <= '0;
      err       <= 1'b0;
    end else begin
      if (state_q == IF_WAIT && inst_rvalid) dec_inst <= inst_rdata;
      if (state_q == EXE) data_addr <= alu_result;
      if (state_q == MEM_WAIT && data_rvalid && dec_is_ld) load_data <= data_rdata;
      if (retire) pc <= br_taken ? br_target : pc + XLEN'(4);
      if (state_d == HALT) err <= 1'b1;
    end
  end
  assign inst_addr   = pc;
  assign debug_wb_pc = pc;
  assign state       = state_q;
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: directed bench driving SRAM handshakes and decode results by hand
module tb_mc_seq_ctrl;
  import mc_pkg::*;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_req, inst_gnt = 1'b0, inst_rvalid = 1'b0;
  logic [31:0] inst_addr, inst_rdata = '0;
  logic        data_req, data_wr, data_gnt = 1'b0, data_rvalid = 1'b0;
  logic [31:0] data_addr, data_rdata = '0;
  logic [31:0] dec_inst;
  logic        dec_is_ld = 1'b0, dec_is_st = 1'b0, dec_no_wb = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = '0, alu_result = '0;
  logic [31:0] pc, load_data, debug_wb_pc;
  logic        rf_we, err;
  logic [2:0]  state;
  logic [3:0]  debug_wb_rf_we;
  int          n_run = 0, n_fail = 0;
  mc_seq_ctrl #(.TMO_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .dec_inst(dec_inst), .dec_is_ld(dec_is_ld), .dec_is_st(dec_is_st),
    .dec_no_wb(dec_no_wb), .br_taken(br_taken), .br_target(br_target),
    .alu_result(alu_result), .pc(pc), .load_data(load_data), .rf_we(rf_we),
    .state(state), .err(err), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_dec(input logic ld, input logic st, input logic nwb, input logic bt,
                         input logic [31:0] tgt, input logic [31:0] alu);
    dec_is_ld  = ld;
    dec_is_st  = st;
    dec_no_wb  = nwb;
    br_taken   = bt;
    br_target  = tgt;
    alu_result = alu;
  endtask
  task automatic fetch(input logic [31:0] addr, input logic [31:0] inst, input int gd, input int rd);
    for (int i = 0; i < gd; i++) begin
      chk("if_req_hold", 32'(inst_req), 32'd1);
      chk("if_addr_hold", inst_addr, addr);
      tick;
    end
    chk("if_req", 32'(inst_req), 32'd1);
    chk("if_addr", inst_addr, addr);
    inst_gnt = 1'b1;
    tick;
    inst_gnt = 1'b0;
    chk("if_wait", 32'(state), 32'(IF_WAIT));
    chk("no_dup_req", 32'(inst_req), 32'd0);
    for (int i = 0; i < rd; i++) tick;
    inst_rvalid = 1'b1;
    inst_rdata  = inst;
    tick;
    inst_rvalid = 1'b0;
    chk("id_state", 32'(state), 32'(ID));
    chk("dec_inst", dec_inst, inst);
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_state", 32'(state), 32'(IF_REQ));
    chk("rst_pc", pc, 32'h1c00_0000);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dec_inst", dec_inst, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_data_req", 32'(data_req), 32'd0);
    resetn = 1'b1;
    fetch(32'h1c00_0000, 32'h0020_81b3, 0, 0);
    set_dec(0, 0, 0, 0, 32'h0, 32'h0);
    chk("add_id_rf_we", 32'(rf_we), 32'd0);
    tick;
    chk("add_exe", 32'(state), 32'(EXE));
    chk("add_exe_rf_we", 32'(rf_we), 32'd0);
    tick;
    chk("add_wb_rf_we", 32'(rf_we), 32'd1);
    chk("add_wb_dbg_we", 32'(debug_wb_rf_we), 32'hf);
    chk("add_wb_dbg_pc", debug_wb_pc, 32'h1c00_0000);
    tick;
    chk("add_post_rf_we", 32'(rf_we), 32'd0);
    chk("add_post_dbg_we", 32'(debug_wb_rf_we), 32'h0);
    chk("add_next_addr", inst_addr, 32'h1c00_0004);
    fetch(32'h1c00_0004, 32'h0000_0013, 3, 0);
    set_dec(0, 0, 1, 0, 32'h0, 32'h0);
    tick;
    chk("nowb_state", 32'(state), 32'(IF_REQ));
    chk("nowb_pc", pc, 32'h1c00_0008);
    fetch(32'h1c00_0008, 32'h0000_2083, 0, 0);
    set_dec(1, 0, 0, 0, 32'h0, 32'h0000_1230);
    tick;
    chk("ld_exe", 32'(state), 32'(EXE));
    tick;
    alu_result = 32'h5555_5555;
    chk("ld_mem_req", 32'(data_req), 32'd1);
    chk("ld_data_wr", 32'(data_wr), 32'd0);
    chk("ld_data_addr", data_addr, 32'h0000_1230);
    chk("ld_no_inst_req", 32'(inst_req), 32'd0);
    data_gnt = 1'b1;
    tick;
    data_gnt = 1'b0;
    chk("ld_mem_wait", 32'(state), 32'(MEM_WAIT));
    chk("ld_req_drop", 32'(data_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ld_wait_hold", 32'(state), 32'(MEM_WAIT));
      tick;
    end
    data_rvalid = 1'b1;
    data_rdata  = 32'hdead_beef;
    tick;
    data_rvalid = 1'b0;
    chk("ld_wb_state", 32'(state), 32'(WB));
    chk("ld_load_data", load_data, 32'hdead_beef);
    chk("ld_rf_we", 32'(rf_we), 32'd1);
    chk("ld_dbg_we", 32'(debug_wb_rf_we), 32'hf);
    tick;
    chk("ld_rf_we_once", 32'(rf_we), 32'd0);
    chk("ld_dbg_we_once", 32'(debug_wb_rf_we), 32'h0);
    chk("ld_next_pc", pc, 32'h1c00_000c);
    fetch(32'h1c00_000c, 32'h0020_a023, 0, 1);
    set_dec(0, 1, 0, 0, 32'h0, 32'h0000_0040);
    tick;
    tick;
    chk("st_data_wr", 32'(data_wr), 32'd1);
    chk("st_data_addr", data_addr, 32'h0000_0040);
    data_gnt = 1'b1;
    tick;
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    tick;
    data_rvalid = 1'b0;
    chk("st_state", 32'(state), 32'(IF_REQ));
    chk("st_no_rf_we", 32'(rf_we), 32'd0);
    chk("st_pc", pc, 32'h1c00_0010);
    set_dec(0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'h1c00_0010, 32'h0e00_0063, 0, 0);
    set_dec(0, 0, 1, 1, 32'h1c00_0100, 32'h0);
    chk("br_id_rf_we", 32'(rf_we), 32'd0);
    tick;
    chk("br_state", 32'(state), 32'(IF_REQ));
    chk("br_rf_we", 32'(rf_we), 32'd0);
    chk("br_addr", inst_addr, 32'h1c00_0100);
    set_dec(0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'h1c00_0100, 32'h0000_006f, 0, 0);
    set_dec(0, 0, 1, 1, 32'hffff_fffc, 32'h0);
    tick;
    chk("br_top_addr", inst_addr, 32'hffff_fffc);
    set_dec(0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'hffff_fffc, 32'h0020_81b3, 0, 0);
    tick;
    tick;
    chk("wrap_wb_pc", debug_wb_pc, 32'hffff_fffc);
    tick;
    chk("wrap_pc", pc, 32'h0);
    for (int i = 0; i < 14; i++) tick;
    chk("tmo_pre_state", 32'(state), 32'(IF_REQ));
    chk("tmo_pre_err", 32'(err), 32'd0);
    tick;
    chk("tmo_halt", 32'(state), 32'(HALT));
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_inst_req", 32'(inst_req), 32'd0);
    inst_gnt    = 1'b1;
    inst_rvalid = 1'b1;
    tick;
    inst_gnt    = 1'b0;
    inst_rvalid = 1'b0;
    chk("halt_absorb", 32'(state), 32'(HALT));
    chk("halt_pc", pc, 32'h0);
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk("halt_rst_err", 32'(err), 32'd0);
    chk("halt_rst_state", 32'(state), 32'(IF_REQ));
    chk("halt_rst_addr", inst_addr, 32'h1c00_0000);
    fetch(32'h1c00_0000, 32'h0000_2083, 0, 0);
    set_dec(1, 0, 0, 0, 32'h0, 32'h0000_0080);
    tick;
    tick;
    data_gnt = 1'b1;
    tick;
    data_gnt = 1'b0;
    chk("rst_mw_state", 32'(state), 32'(MEM_WAIT));
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk("rst_mw_to_ifreq", 32'(state), 32'(IF_REQ));
    chk("rst_mw_data_req", 32'(data_req), 32'd0);
    data_rvalid = 1'b1;
    data_rdata  = 32'hcafe_f00d;
    inst_rvalid = 1'b1;
    inst_rdata  = 32'h1234_5678;
    tick;
    data_rvalid = 1'b0;
    inst_rvalid = 1'b0;
    chk("stale_state", 32'(state), 32'(IF_REQ));
    chk("stale_load_data", load_data, 32'h0);
    chk("stale_dec_inst", dec_inst, 32'h0);
    chk("stale_pc", pc, 32'h1c00_0000);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_seq_ctrl.md
MC_SEQ_CTRL -- requirements
Module: mc_seq_ctrl

Interface
REQ-001 Parameter XLEN, default 32: PC/address width.
REQ-002 Parameter RESET_PC, default 32'h1c00_0000: first fetch address.
REQ-003 Parameter TMO_W, default 8: width of response-timeout counter; timeout limit = 2^TMO_W-1 cycles.
REQ-004 clk  in  1  sole clock; all state changes on posedge clk.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 inst_req out 1, inst_addr out XLEN, inst_gnt in 1, inst_rvalid in 1, inst_rdata in 32: instruction SRAM request/grant/response.
REQ-007 data_req out 1, data_wr out 1, data_addr out XLEN, data_gnt in 1, data_rvalid in 1, data_rdata in 32: data SRAM request/grant/response.
REQ-008 dec_inst out 32: latched instruction, driven to external decoder.
REQ-009 dec_is_ld, dec_is_st, dec_no_wb, br_taken in 1 each; br_target, alu_result in XLEN: combinational decode/execute results for dec_inst.
REQ-010 pc out XLEN, load_data out 32, rf_we out 1, state out 3, err out 1, debug_wb_pc out XLEN, debug_wb_rf_we out 4.

Function
REQ-011 States: IF_REQ, IF_WAIT, ID, EXE, MEM_REQ, MEM_WAIT, WB, HALT; encoding exported on state.
REQ-012 IF_REQ: inst_req=1, inst_addr=pc; inst_req and inst_addr held stable until inst_gnt; on inst_gnt -> IF_WAIT.
REQ-013 IF_WAIT: on inst_rvalid latch inst_rdata into dec_inst -> ID; inst_rvalid in same cycle as inst_gnt ignored (response ≥1 cycle after grant).
REQ-014 ID: one cycle; dec_no_wb=1 -> pc updated, next IF_REQ; else -> EXE.
REQ-015 EXE: one cycle; dec_is_ld|dec_is_st -> MEM_REQ; else -> WB.
REQ-016 MEM_REQ: data_req=1, data_wr=dec_is_st, data_addr=alu_result latched on EXE exit; held until data_gnt -> MEM_WAIT.
REQ-017 MEM_WAIT: on data_rvalid: load latches data_rdata into load_data -> WB; store -> pc update, IF_REQ.
REQ-018 WB: rf_we=1 for exactly one cycle; debug_wb_rf_we=4'hf that cycle, else 0; debug_wb_pc=pc of retiring instruction; -> pc update, IF_REQ.
REQ-019 PC update occurs exactly once per instruction, on the leaving edge of its last state: pc <= br_taken ? br_target : pc+4 (modulo 2^XLEN, wraps silently).
REQ-020 Timeout counter clears on entry to IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT; increments each cycle there; reaching 2^TMO_W-1 without the awaited gnt/rvalid -> HALT, err=1.
REQ-021 HALT: absorbing until reset; inst_req=data_req=rf_we=0; pc frozen.
REQ-022 Unexpected inst_rvalid/data_rvalid outside the matching WAIT state ignored.
REQ-023 At most one request outstanding; inst_req and data_req never both 1.

Reset
REQ-024 resetn=0 at posedge: state=IF_REQ, pc=RESET_PC, dec_inst=0, load_data=0, err=0, timeout=0; all strobes (inst_req excepted) 0 that cycle.
REQ-025 Reset mid-request abandons the transaction; a late rvalid after reset is ignored unless in IF_WAIT after a new grant.
REQ-026 inst_req asserts in first cycle after reset release.

Structure
REQ-027 State encodings and RESET_PC default in shared package mc_pkg.
REQ-028 One sub-module natural: mc_tmo_cnt (TMO_W counter, clear/enable/expired).
REQ-029 No combinational path from *_rvalid to *_req.

Verification
REQ-030 Reset, zero-wait SRAM (gnt same cycle, rvalid next), ADD instruction -> first inst_addr=0x1c000000, rf_we pulse 5 cycles after reset release, next inst_addr=0x1c000004.
REQ-031 Fetch with inst_gnt delayed 3 cycles -> inst_addr stable all 4 cycles, no duplicate request after grant.
REQ-032 Load with data_rvalid delayed 5 cycles, data 0xdeadbeef -> load_data=0xdeadbeef, single rf_we pulse, debug_wb_rf_we=4'hf once.
REQ-033 Taken branch br_target=0x1c000100 (dec_no_wb) -> no rf_we, next inst_addr=0x1c000100; pc=0xfffffffc non-branch -> next pc=0x0.
REQ-034 TMO_W=4, inst_gnt never asserted -> HALT and err=1 after 15 cycles in IF_REQ; resetn low -> err=0, fetch restarts at RESET_PC.
REQ-035 resetn pulsed during MEM_WAIT, then stale data_rvalid -> ignored, state IF_REQ, pc=RESET_PC.
